// File: rtl/psum_accum_pkg.sv
// Shared constants and types for the partial-sum accumulator and the
// downstream requantize/pack stage.
package psum_accum_pkg;

    // Accumulator and result width. The requantizer also sizes its input from this.
    localparam int ACC_W     = 32;
    localparam int NUM_LANES = 4;

    localparam logic [ACC_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [ACC_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/sat_add32.sv
// Combinational signed add with clamping to the 32-bit two's-complement range.
module sat_add32
    import psum_accum_pkg::*;
(
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o
);

    logic [ACC_W:0] wide;

    // One extra bit holds the true sum, so overflow is visible in the top two bits.
    assign wide = {a_i[ACC_W-1], a_i} + {b_i[ACC_W-1], b_i};

    // Pick the clamped value when the two top bits of the wide sum disagree.
    always_comb begin
        // NOTE: assigning a default before the case means every path drives sum_o, so no latch is inferred.
        sum_o = wide[ACC_W-1:0];
        case (wide[ACC_W:ACC_W-1])
            2'b01:   sum_o = SAT_MAX;
            2'b10:   sum_o = SAT_MIN;
            default: sum_o = wide[ACC_W-1:0];
        endcase
    end

endmodule

// File: rtl/psum_accum.sv
// Four-lane partial-sum accumulator with per-tile bias load, saturating
// accumulation and a one-entry valid/ready result slot.
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int PSUM_W = 20,
    parameter int BIAS_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic signed [PSUM_W-1:0] psum0,
    input  logic signed [PSUM_W-1:0] psum1,
    input  logic signed [PSUM_W-1:0] psum2,
    input  logic signed [PSUM_W-1:0] psum3,
    input  logic signed [BIAS_W-1:0] bias0,
    input  logic signed [BIAS_W-1:0] bias1,
    input  logic signed [BIAS_W-1:0] bias2,
    input  logic signed [BIAS_W-1:0] bias3,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out0,
    output logic signed [ACC_W-1:0]  out1,
    output logic signed [ACC_W-1:0]  out2,
    output logic signed [ACC_W-1:0]  out3,
    output logic [CNT_W-1:0]         beat_cnt,
    output logic [CNT_W-1:0]         tile_cnt,
    output logic                     err
);

    logic [NUM_LANES-1:0][PSUM_W-1:0] psum_a;
    logic [NUM_LANES-1:0][BIAS_W-1:0] bias_a;
    logic [NUM_LANES-1:0][ACC_W-1:0]  base;
    logic [NUM_LANES-1:0][ACC_W-1:0]  sum;

    state_e                           state_q, state_d;
    logic [NUM_LANES-1:0][ACC_W-1:0]  acc_q, acc_d;
    logic [NUM_LANES-1:0][ACC_W-1:0]  out_q, out_d;
    logic                             out_valid_q, out_valid_d;
    logic [CNT_W-1:0]                 beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]                 tile_cnt_q, tile_cnt_d;
    logic                             err_q, err_d;
    logic                             accept;

    assign psum_a = {psum3, psum2, psum1, psum0};
    assign bias_a = {bias3, bias2, bias1, bias0};

    // A last beat is held off only while the slot is full and not draining,
    // since its commit would overwrite the held result.
    assign in_ready = !(out_valid_q && !out_ready) || !(in_valid && in_last);
    assign accept   = in_valid && in_ready;

    // Per lane: the first beat starts from the bias, later beats from the accumulator.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign base[i] = in_first ? {{(ACC_W-BIAS_W){bias_a[i][BIAS_W-1]}}, bias_a[i]}
                                  : acc_q[i];
        sat_add32 u_add (
            .a_i   (base[i]),
            .b_i   ({{(ACC_W-PSUM_W){psum_a[i][PSUM_W-1]}}, psum_a[i]}),
            .sum_o (sum[i])
        );
    end

    // Next-state logic for the tile FSM, accumulators, counters and result slot.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        beat_cnt_d  = beat_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        err_d       = err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (state_q == ST_IDLE && !in_first) begin
                // A beat with no open tile carries nothing to add to; drop it.
                err_d = 1'b1;
            end else begin
                acc_d = sum;
                if (in_first) begin
                    beat_cnt_d = CNT_W'(1);
                    if (state_q == ST_ACC) begin
                        err_d = 1'b1;
                    end
                end else if (beat_cnt_q != '1) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end

                if (in_last) begin
                    out_d       = sum;
                    out_valid_d = 1'b1;
                    tile_cnt_d  = tile_cnt_q + CNT_W'(1);
                    beat_cnt_d  = '0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_ACC;
                end
            end
        end
    end

    // State register; reset discards any partial tile and any held result.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the accumulators are datapath registers but are still reset, because a reset mid-tile must not leak old partial sums into the next tile.
        if (!rstn) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
            tile_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values, independent of statement order.
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            beat_cnt_q  <= beat_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            err_q       <= err_d;
        end
    end

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out_valid = out_valid_q;
    assign beat_cnt  = beat_cnt_q;
    assign tile_cnt  = tile_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_psum_accum.sv
// Directed testbench for psum_accum: tile accumulation, single-beat tiles,
// saturation, backpressure, protocol errors and asynchronous reset.
module tb_psum_accum;

    logic               clk;
    logic               rstn;
    logic               in_valid;
    logic               in_ready;
    logic               in_first;
    logic               in_last;
    logic signed [19:0] psum0, psum1, psum2, psum3;
    logic signed [15:0] bias0, bias1, bias2, bias3;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out0, out1, out2, out3;
    logic [15:0]        beat_cnt;
    logic [15:0]        tile_cnt;
    logic               err;

    int checks   = 0;
    int failures = 0;

    psum_accum dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .psum0     (psum0),
        .psum1     (psum1),
        .psum2     (psum2),
        .psum3     (psum3),
        .bias0     (bias0),
        .bias1     (bias1),
        .bias2     (bias2),
        .bias3     (bias3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .beat_cnt  (beat_cnt),
        .tile_cnt  (tile_cnt),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic first, input logic last,
                         input int p0, input int p1, input int p2, input int p3,
                         input int b0, input int b1, input int b2, input int b3);
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        psum0 = 20'(p0); psum1 = 20'(p1); psum2 = 20'(p2); psum3 = 20'(p3);
        bias0 = 16'(b0); bias1 = 16'(b1); bias2 = 16'(b2); bias3 = 16'(b3);
    endtask

    task automatic beat(input logic first, input logic last,
                        input int p0, input int p1, input int p2, input int p3,
                        input int b0, input int b1, input int b2, input int b3);
        drive(first, last, p0, p1, p2, p3, b0, b1, b2, b3);
        step();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        psum0 = '0; psum1 = '0; psum2 = '0; psum3 = '0;
        bias0 = '0; bias1 = '0; bias2 = '0; bias3 = '0;

        // Reset state
        #2;
        check("rst_out0",      out0, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_beat_cnt",  32'(beat_cnt), 32'd0);
        check("rst_tile_cnt",  32'(tile_cnt), 32'd0);
        check("rst_err",       32'(err), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        #10 rstn = 1'b1;

        // 3-beat tile: lane0 = 100+5-3+10, other lanes = 1+1+1
        beat(1'b1, 1'b0,  5, 1, 1, 1, 100, 0, 0, 0);
        check("t1_beat_cnt1", 32'(beat_cnt), 32'd1);
        check("t1_no_valid",  32'(out_valid), 32'd0);
        beat(1'b0, 1'b0, -3, 1, 1, 1, 0, 0, 0, 0);
        check("t1_beat_cnt2", 32'(beat_cnt), 32'd2);
        beat(1'b0, 1'b1, 10, 1, 1, 1, 0, 0, 0, 0);
        check("t1_out0",      out0, 32'd112);
        check("t1_out1",      out1, 32'd3);
        check("t1_out2",      out2, 32'd3);
        check("t1_out3",      out3, 32'd3);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_tile_cnt",  32'(tile_cnt), 32'd1);
        check("t1_beat_clr",  32'(beat_cnt), 32'd0);
        step();
        check("t1_drained",   32'(out_valid), 32'd0);

        // Single-beat tile: lane2 = -7 + -1
        beat(1'b1, 1'b1, 0, 0, -1, 0, 0, 0, -7, 0);
        check("t2_out2",      out2, 32'hFFFF_FFF8);
        check("t2_out0",      out0, 32'd0);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_beat_cnt",  32'(beat_cnt), 32'd0);
        check("t2_tile_cnt",  32'(tile_cnt), 32'd2);
        step();

        // Positive saturation: 32767 + 5000 * 524287 exceeds 2^31-1
        beat(1'b1, 1'b0, 0, 524287, 0, 0, 0, 32767, 0, 0);
        for (int i = 0; i < 4998; i++) beat(1'b0, 1'b0, 0, 524287, 0, 0, 0, 0, 0, 0);
        check("sat_pos_beat_cnt", 32'(beat_cnt), 32'd4999);
        beat(1'b0, 1'b1, 0, 524287, 0, 0, 0, 0, 0, 0);
        check("sat_pos_out1",     out1, 32'h7FFF_FFFF);
        check("sat_pos_out0",     out0, 32'd0);
        check("sat_pos_tile_cnt", 32'(tile_cnt), 32'd3);
        step();

        // Negative saturation: -32768 + 5000 * -524288 is below -2^31
        beat(1'b1, 1'b0, 0, -524288, 0, 0, 0, -32768, 0, 0);
        for (int i = 0; i < 4998; i++) beat(1'b0, 1'b0, 0, -524288, 0, 0, 0, 0, 0, 0);
        beat(1'b0, 1'b1, 0, -524288, 0, 0, 0, 0, 0, 0);
        check("sat_neg_out1",     out1, 32'h8000_0000);
        check("sat_neg_tile_cnt", 32'(tile_cnt), 32'd4);
        step();

        // Backpressure: tile A (1+2+3=6) held, tile B (10+1+2+4=17) streams behind it
        out_ready = 1'b0;
        beat(1'b1, 1'b0, 2, 0, 0, 0, 1, 0, 0, 0);
        beat(1'b0, 1'b1, 3, 0, 0, 0, 0, 0, 0, 0);
        check("bp_a_out0",      out0, 32'd6);
        check("bp_a_valid",     32'(out_valid), 32'd1);
        drive(1'b1, 1'b0, 1, 0, 0, 0, 10, 0, 0, 0);
        #1;
        check("bp_b_first_rdy", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 1'b0, 2, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("bp_b_mid_rdy",   32'(in_ready), 32'd1);
        step();
        drive(1'b0, 1'b1, 4, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("bp_b_last_stall", 32'(in_ready), 32'd0);
        step();
        check("bp_hold_out0",   out0, 32'd6);
        check("bp_hold_valid",  32'(out_valid), 32'd1);
        check("bp_hold_beats",  32'(beat_cnt), 32'd2);
        check("bp_hold_tiles",  32'(tile_cnt), 32'd5);
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_b_out0",      out0, 32'd17);
        check("bp_b_valid",     32'(out_valid), 32'd1);
        check("bp_b_tile_cnt",  32'(tile_cnt), 32'd6);
        check("bp_b_beat_cnt",  32'(beat_cnt), 32'd0);
        check("bp_err_clean",   32'(err), 32'd0);
        step();
        check("bp_b_drained",   32'(out_valid), 32'd0);

        // Protocol errors: orphan beat dropped, then a mid-tile restart (30+3+4=37)
        beat(1'b0, 1'b0, 50, 0, 0, 0, 0, 0, 0, 0);
        check("pe_orphan_err",   32'(err), 32'd1);
        check("pe_orphan_beats", 32'(beat_cnt), 32'd0);
        beat(1'b1, 1'b0, 1, 0, 0, 0, 20, 0, 0, 0);
        beat(1'b0, 1'b0, 2, 0, 0, 0, 0, 0, 0, 0);
        check("pe_mid_beats",    32'(beat_cnt), 32'd2);
        beat(1'b1, 1'b0, 3, 0, 0, 0, 30, 0, 0, 0);
        check("pe_restart_beats", 32'(beat_cnt), 32'd1);
        beat(1'b0, 1'b1, 4, 0, 0, 0, 0, 0, 0, 0);
        check("pe_out0",         out0, 32'd37);
        check("pe_tile_cnt",     32'(tile_cnt), 32'd7);
        check("pe_err_sticky",   32'(err), 32'd1);

        // Asynchronous reset mid-tile while a result is held
        out_ready = 1'b0;
        beat(1'b1, 1'b0, 5, 0, 0, 0, 5, 0, 0, 0);
        beat(1'b0, 1'b0, 5, 0, 0, 0, 0, 0, 0, 0);
        check("ar_pre_valid", 32'(out_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("ar_out0",      out0, 32'd0);
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_beat_cnt",  32'(beat_cnt), 32'd0);
        check("ar_tile_cnt",  32'(tile_cnt), 32'd0);
        check("ar_err",       32'(err), 32'd0);
        check("ar_in_ready",  32'(in_ready), 32'd1);
        #3 rstn = 1'b1;
        out_ready = 1'b1;
        beat(1'b1, 1'b0, 1, 0, 0, 0, 7, 0, 0, 0);
        beat(1'b0, 1'b1, 2, 0, 0, 0, 0, 0, 0, 0);
        check("ar_new_out0",     out0, 32'd10);
        check("ar_new_tile_cnt", 32'(tile_cnt), 32'd1);
        check("ar_new_err",      32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
